// File: rtl/xgmii_rx_stats_if.sv
// Purpose : 64-bit XGMII receive bus (8 lanes of data plus per-lane control flags).
// Latency : n/a, wires only.
// Backpressure: none; XGMII is a continuous stream with no ready signal.
//   xgmii_rxd : lane i = bits [8i+7:8i], lane 0 first on the wire
//   xgmii_rxc : bit i set marks lane i as a control character
interface xgmii_rx_stats_if;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;

    modport master (output xgmii_rxd, xgmii_rxc);
    modport slave  (input  xgmii_rxd, xgmii_rxc);
endinterface

// File: rtl/xgmii_rx_stats.sv
// Purpose : passive XGMII RX monitor; delineates frames, flags preamble/length/control
//           errors and keeps saturating good/bad frame and good byte counters.
// Latency : 1 cycle from the sampled word to every output (all outputs registered).
// Backpressure: none; the stream is only observed, never stalled or modified.
// Ports:
//   clk156, sys_rst      : sole clock, synchronous active-high reset
//   stats_clear          : zeroes the three counters; frame tracking carries on
//   xgmii (slave)        : xgmii_rxd / xgmii_rxc from the lane-alignment stage
//   rx_active            : inside a frame
//   frame_done/frame_good: one-cycle close pulse and its good/bad qualifier
//   last_len             : length of the most recently closed frame
//   good_frames, bad_frames, good_bytes : saturating statistics
module xgmii_rx_stats #(
    parameter int CNT_WIDTH = 32,   // must be at least 16 (good_bytes accumulates last_len)
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518
) (
    input  logic                  clk156,
    input  logic                  sys_rst,
    input  logic                  stats_clear,
    xgmii_rx_stats_if.slave       xgmii,
    output logic                  rx_active,
    output logic                  frame_done,
    output logic                  frame_good,
    output logic [15:0]           last_len,
    output logic [CNT_WIDTH-1:0]  good_frames,
    output logic [CNT_WIDTH-1:0]  bad_frames,
    output logic [CNT_WIDTH-1:0]  good_bytes
);
    localparam logic [15:0]          MIN_L   = 16'(MIN_LEN);
    localparam logic [15:0]          MAX_L   = 16'(MAX_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE, ST_DATA} state_t;

    state_t      state, state_nxt;
    logic [15:0] len_q, len_nxt;
    logic        err_q, err_nxt;

    logic        is_start, pre_err, term_ok;
    logic [2:0]  k;
    logic [15:0] len_add, len_sat;
    logic [16:0] len_sum;

    logic        close_vld, close_good;
    logic [15:0] close_len;

    logic [CNT_WIDTH:0] gb_sum;

    // Word decode: start/preamble check, first control lane and terminate shape.
    always_comb begin
        is_start = (xgmii.xgmii_rxc == 8'h01) && (xgmii.xgmii_rxd[7:0] == 8'hFB);
        pre_err  = (xgmii.xgmii_rxd[63:8] != 56'hD5_55_55_55_55_55_55);
        k = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (xgmii.xgmii_rxc[i]) begin
                k = 3'(i);
            end
        end
        // A clean terminate is FD in lane k with every lane from k upward a control lane.
        term_ok = (xgmii.xgmii_rxd[{k, 3'b000} +: 8] == 8'hFD)
                  && (xgmii.xgmii_rxc == (8'hFF << k));
        len_add = (xgmii.xgmii_rxc == 8'h00) ? 16'd8 : {13'd0, k};
        len_sum = {1'b0, len_q} + {1'b0, len_add};
        len_sat = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    end

    // Next-state and frame-close decisions.
    always_comb begin
        state_nxt  = state;
        len_nxt    = len_q;
        err_nxt    = err_q;
        close_vld  = 1'b0;
        close_good = 1'b0;
        close_len  = len_sat;
        case (state)
            ST_IDLE: begin
                if (is_start) begin
                    state_nxt = ST_DATA;
                    len_nxt   = 16'd0;
                    err_nxt   = pre_err;
                end
            end
            ST_DATA: begin
                if (is_start) begin
                    // Missing terminate: close the old frame bad and open the new one
                    // from this same word.
                    close_vld = 1'b1;
                    close_len = len_q;
                    len_nxt   = 16'd0;
                    err_nxt   = pre_err;
                end else if (xgmii.xgmii_rxc == 8'h00) begin
                    len_nxt = len_sat;
                end else begin
                    close_vld  = 1'b1;
                    close_good = term_ok && !err_q && (len_sat >= MIN_L) && (len_sat <= MAX_L);
                    len_nxt    = len_sat;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign gb_sum = {1'b0, good_bytes} + {{(CNT_WIDTH+1-16){1'b0}}, close_len};

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            len_q       <= 16'd0;
            err_q       <= 1'b0;
            frame_done  <= 1'b0;
            frame_good  <= 1'b0;
            last_len    <= 16'd0;
            good_frames <= '0;
            bad_frames  <= '0;
            good_bytes  <= '0;
        end else begin
            state      <= state_nxt;
            len_q      <= len_nxt;
            err_q      <= err_nxt;
            frame_done <= close_vld;
            frame_good <= close_vld && close_good;
            if (close_vld) begin
                last_len <= close_len;
            end
            // Clear wins over a coincident close; that frame is simply not counted.
            if (stats_clear) begin
                good_frames <= '0;
                bad_frames  <= '0;
                good_bytes  <= '0;
            end else if (close_vld) begin
                if (close_good) begin
                    if (good_frames != '1) begin
                        good_frames <= good_frames + CNT_ONE;
                    end
                    good_bytes <= gb_sum[CNT_WIDTH] ? '1 : gb_sum[CNT_WIDTH-1:0];
                end else if (bad_frames != '1) begin
                    bad_frames <= bad_frames + CNT_ONE;
                end
            end
        end
    end

    // State is itself a register, so this output is registered.
    assign rx_active = (state == ST_DATA);

endmodule

// File: tb/tb_xgmii_rx_stats.sv
// Purpose : self-checking bench for xgmii_rx_stats (default and jumbo MAX_LEN instances).
// Latency : expects every output one cycle after the sampled word.
// Backpressure: none; stimulus is a free-running XGMII word per cycle.
module tb_xgmii_rx_stats;
    logic clk156 = 1'b0;
    always #5 clk156 = ~clk156;

    logic sys_rst;
    logic stats_clear;
    xgmii_rx_stats_if xif ();

    logic        rx_active, frame_done, frame_good;
    logic [15:0] last_len;
    logic [31:0] good_frames, bad_frames, good_bytes;
    logic        j_rx_active, j_frame_done, j_frame_good;
    logic [15:0] j_last_len;
    logic [31:0] j_good_frames, j_bad_frames, j_good_bytes;

    xgmii_rx_stats #(.CNT_WIDTH(32), .MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk156(clk156), .sys_rst(sys_rst), .stats_clear(stats_clear), .xgmii(xif),
        .rx_active(rx_active), .frame_done(frame_done), .frame_good(frame_good),
        .last_len(last_len), .good_frames(good_frames), .bad_frames(bad_frames),
        .good_bytes(good_bytes));

    xgmii_rx_stats #(.CNT_WIDTH(32), .MIN_LEN(64), .MAX_LEN(9018)) dut_jumbo (
        .clk156(clk156), .sys_rst(sys_rst), .stats_clear(stats_clear), .xgmii(xif),
        .rx_active(j_rx_active), .frame_done(j_frame_done), .frame_good(j_frame_good),
        .last_len(j_last_len), .good_frames(j_good_frames), .bad_frames(j_bad_frames),
        .good_bytes(j_good_bytes));

    typedef struct packed { logic good; logic [15:0] len; } close_t;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam int MAXL0 = 1518;
    localparam int MAXL1 = 9018;

    close_t obs_q[$], j_obs_q[$], exp_q[$], j_exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     m_gf[2], m_bf[2];
    longint m_gb[2];

    // Observed frame closes, recorded away from the active edge.
    always @(negedge clk156) begin
        if (frame_done === 1'b1)   obs_q.push_back({frame_good, last_len});
        if (j_frame_done === 1'b1) j_obs_q.push_back({j_frame_good, j_last_len});
    end

    // Reference model: a frame closes with a length and a "clean" flag (good preamble,
    // proper terminate); goodness is then just the legal length window per instance.
    function automatic void model_close(input int len, input bit clean, input bit clr);
        int maxl;
        bit good;
        for (int i = 0; i < 2; i++) begin
            maxl = (i == 0) ? MAXL0 : MAXL1;
            good = clean && (len >= 64) && (len <= maxl);
            if (i == 0) exp_q.push_back({good, 16'(len)});
            else        j_exp_q.push_back({good, 16'(len)});
            if (clr) begin
                m_gf[i] = 0; m_bf[i] = 0; m_gb[i] = 0;
            end else if (good) begin
                m_gf[i]++; m_gb[i] += len;
            end else begin
                m_bf[i]++;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_gf[i] = 0; m_bf[i] = 0; m_gb[i] = 0;
        end
    endfunction

    task automatic flush_q();
        obs_q.delete(); j_obs_q.delete(); exp_q.delete(); j_exp_q.delete();
    endtask

    task automatic put(input logic [63:0] d, input logic [7:0] c, input logic clr);
        @(negedge clk156);
        xif.xgmii_rxd = d;
        xif.xgmii_rxc = c;
        stats_clear   = clr;
    endtask

    task automatic idles(input int n);
        repeat (n) put(IDLE_W, 8'hFF, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk156);
        sys_rst = 1'b1;
        xif.xgmii_rxd = IDLE_W;
        xif.xgmii_rxc = 8'hFF;
        stats_clear = 1'b0;
        repeat (2) @(negedge clk156);
        sys_rst = 1'b0;
        model_reset();
    endtask

    // ending: 0 = FD terminate, 1 = FE in the terminate lane, 2 = stop after whole words
    // (next start word aborts it), 3 = stop after whole words with no model update.
    task automatic send_frame(input int nbytes, input int bad_lane, input int ending, input bit clr_end);
        logic [63:0] w;
        logic [7:0]  c;
        int nw, r, len;
        nw = nbytes / 8;
        r  = nbytes % 8;
        w  = 64'hD555_5555_5555_55FB;
        if (bad_lane != 0) w[bad_lane*8 +: 8] = 8'h54;
        put(w, 8'h01, 1'b0);
        for (int i = 0; i < nw; i++) put({$urandom, $urandom}, 8'h00, 1'b0);
        if (ending >= 2) begin
            len = (nw * 8 > 65535) ? 65535 : nw * 8;
            if (ending == 2) model_close(len, 1'b0, 1'b0);
            return;
        end
        w = {$urandom, $urandom};
        for (int j = r; j < 8; j++) w[j*8 +: 8] = (j != r) ? 8'h07 : ((ending == 0) ? 8'hFD : 8'hFE);
        c = 8'hFF << r;
        put(w, c, clr_end);
        len = (nbytes > 65535) ? 65535 : nbytes;
        model_close(len, (ending == 0) && (bad_lane == 0), clr_end);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({rx_active, frame_done, frame_good, last_len, good_frames, bad_frames, good_bytes} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got act=%b done=%b good=%b len=%0d gf=%0d bf=%0d gb=%0d want all 0",
                     rx_active, frame_done, frame_good, last_len, good_frames, bad_frames, good_bytes);
        end
        checks++;
        if ({j_rx_active, j_frame_done, j_frame_good, j_last_len, j_good_frames, j_bad_frames, j_good_bytes} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_jumbo: got act=%b done=%b gf=%0d want all 0", j_rx_active, j_frame_done, j_good_frames);
        end
        flush_q();
    endtask

    task automatic test_standard();
        send_frame(64, 0, 0, 1'b0);
        put(IDLE_W, 8'hFF, 1'b0);
        #1;
        checks++;
        if ({frame_done, frame_good, last_len, rx_active} !== {1'b1, 1'b1, 16'd64, 1'b0}) begin
            errors++;
            $display("FAIL std_pulse: got done=%b good=%b len=%0d act=%b want 1 1 64 0", frame_done, frame_good, last_len, rx_active);
        end
        put(IDLE_W, 8'hFF, 1'b0);
        #1;
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL std_pulse_width: got done=%b want 0", frame_done);
        end
        checks++;
        if ({good_frames, bad_frames, good_bytes} !== {32'(m_gf[0]), 32'(m_bf[0]), 32'(m_gb[0])}) begin
            errors++;
            $display("FAIL std_counters: got gf=%0d bf=%0d gb=%0d want gf=%0d bf=%0d gb=%0d",
                     good_frames, bad_frames, good_bytes, m_gf[0], m_bf[0], m_gb[0]);
        end
        flush_q();
    endtask

    task automatic test_back_to_back();
        int act_bad = 0;
        do_reset();
        flush_q();
        for (int n = 0; n < 1000; n++) begin
            send_frame(64, 0, 0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                put(IDLE_W, 8'hFF, 1'b0);
                #1;
                if (rx_active !== 1'b0) act_bad++;
            end
        end
        checks++;
        if (act_bad != 0) begin
            errors++;
            $display("FAIL b2b_rx_active_idle: got %0d cycles high want 0", act_bad);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_close_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if ({good_frames, bad_frames, good_bytes} !== {32'd1000, 32'd0, 32'd64000}
            || {good_frames, good_bytes} !== {32'(m_gf[0]), 32'(m_gb[0])}) begin
            errors++;
            $display("FAIL b2b_counters: got gf=%0d bf=%0d gb=%0d want gf=1000 bf=0 gb=64000",
                     good_frames, bad_frames, good_bytes);
        end
        flush_q();
    endtask

    // Closes listed in exp_q are compared one by one, then the default instance counters.
    task automatic test_errors_and_bounds();
        flush_q();
        send_frame(59, 0, 0, 1'b0);   // runt terminated in lane 3
        send_frame(42, 0, 1, 1'b0);   // FE in lane 2
        send_frame(64, 4, 0, 1'b0);   // preamble lane 4 = 54
        send_frame(63, 0, 0, 1'b0);
        send_frame(1518, 0, 0, 1'b0);
        send_frame(1519, 0, 0, 1'b0);
        send_frame(24, 0, 2, 1'b0);   // aborted by the next start word
        send_frame(64, 0, 0, 1'b0);
        idles(3);
        #1;
        checks++;
        if (rx_active !== 1'b0) begin
            errors++;
            $display("FAIL err_idle_state: got act=%b want 0", rx_active);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL err_close_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL err_close[%0d]: got good=%b len=%0d want good=%b len=%0d",
                             i, obs_q[i].good, obs_q[i].len, exp_q[i].good, exp_q[i].len);
                end
            end
        end
        checks++;
        if ({good_frames, bad_frames, good_bytes} !== {32'(m_gf[0]), 32'(m_bf[0]), 32'(m_gb[0])}) begin
            errors++;
            $display("FAIL err_counters: got gf=%0d bf=%0d gb=%0d want gf=%0d bf=%0d gb=%0d",
                     good_frames, bad_frames, good_bytes, m_gf[0], m_bf[0], m_gb[0]);
        end
        flush_q();
    endtask

    task automatic test_oversize();
        flush_q();
        send_frame(1600, 0, 0, 1'b0);
        idles(2);
        send_frame(9000, 0, 0, 1'b0);
        idles(2);
        send_frame(66000, 0, 0, 1'b0);  // internal length saturates
        idles(3);
        #1;
        checks++;
        if (obs_q.size() != 3 || j_obs_q.size() != 3) begin
            errors++;
            $display("FAIL big_close_count: got %0d/%0d want 3/3", obs_q.size(), j_obs_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < obs_q.size() && i < j_obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i] || j_obs_q[i] !== j_exp_q[i]) begin
                    errors++;
                    $display("FAIL big_close[%0d]: got good=%b/%b len=%0d/%0d want good=%b/%b len=%0d/%0d",
                             i, obs_q[i].good, j_obs_q[i].good, obs_q[i].len, j_obs_q[i].len,
                             exp_q[i].good, j_exp_q[i].good, exp_q[i].len, j_exp_q[i].len);
                end
            end
        end
        checks++;
        if ({j_good_frames, j_bad_frames, j_good_bytes} !== {32'(m_gf[1]), 32'(m_bf[1]), 32'(m_gb[1])}) begin
            errors++;
            $display("FAIL big_counters_jumbo: got gf=%0d bf=%0d gb=%0d want gf=%0d bf=%0d gb=%0d",
                     j_good_frames, j_bad_frames, j_good_bytes, m_gf[1], m_bf[1], m_gb[1]);
        end
        checks++;
        if ({good_frames, bad_frames, good_bytes} !== {32'(m_gf[0]), 32'(m_bf[0]), 32'(m_gb[0])}) begin
            errors++;
            $display("FAIL big_counters: got gf=%0d bf=%0d gb=%0d want gf=%0d bf=%0d gb=%0d",
                     good_frames, bad_frames, good_bytes, m_gf[0], m_bf[0], m_gb[0]);
        end
        flush_q();
    endtask

    task automatic test_stats_clear();
        send_frame(64, 0, 0, 1'b1);
        put(IDLE_W, 8'hFF, 1'b0);
        #1;
        checks++;
        if ({frame_done, frame_good, last_len} !== {1'b1, 1'b1, 16'd64}) begin
            errors++;
            $display("FAIL clr_pulse: got done=%b good=%b len=%0d want 1 1 64", frame_done, frame_good, last_len);
        end
        checks++;
        if ({good_frames, bad_frames, good_bytes, j_good_frames, j_bad_frames, j_good_bytes} !== '0) begin
            errors++;
            $display("FAIL clr_counters: got gf=%0d bf=%0d gb=%0d jgf=%0d want all 0",
                     good_frames, bad_frames, good_bytes, j_good_frames);
        end
        idles(2);
        flush_q();
    endtask

    task automatic test_reset_midframe();
        send_frame(64, 0, 0, 1'b0);   // leaves nonzero counters for reset to clear
        send_frame(24, 0, 3, 1'b0);
        #1;
        checks++;
        if (rx_active !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_active: got act=%b want 1", rx_active);
        end
        flush_q();
        do_reset();
        idles(2);
        #1;
        checks++;
        if (obs_q.size() != 0 || {rx_active, good_frames, bad_frames, good_bytes} !== '0) begin
            errors++;
            $display("FAIL rst_mid_discard: got closes=%0d act=%b gf=%0d bf=%0d want 0 0 0 0",
                     obs_q.size(), rx_active, good_frames, bad_frames);
        end
        send_frame(64, 0, 0, 1'b0);
        idles(2);
        #1;
        checks++;
        if ({good_frames, bad_frames, good_bytes} !== {32'd1, 32'd0, 32'd64} || obs_q.size() != 1) begin
            errors++;
            $display("FAIL rst_mid_next: got gf=%0d bf=%0d gb=%0d closes=%0d want 1 0 64 1",
                     good_frames, bad_frames, good_bytes, obs_q.size());
        end
        flush_q();
    endtask

    task automatic test_random();
        int nb, bl, en, nfr;
        nfr = 60;
        flush_q();
        for (int n = 0; n < nfr; n++) begin
            nb = $urandom_range(0, 1700);
            bl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 0;
            en = $urandom_range(0, 9);
            en = (en < 7) ? 0 : ((en < 9) ? 1 : 2);
            if (n == nfr - 1) en = 0;
            send_frame(nb, bl, en, 1'b0);
            if (en != 2) idles($urandom_range(0, 3));
        end
        idles(3);
        #1;
        checks++;
        if (obs_q.size() != exp_q.size() || j_obs_q.size() != j_exp_q.size()) begin
            errors++;
            $display("FAIL rand_close_count: got %0d/%0d want %0d/%0d",
                     obs_q.size(), j_obs_q.size(), exp_q.size(), j_exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < obs_q.size() && i < j_obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i] || j_obs_q[i] !== j_exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_close[%0d]: got good=%b/%b len=%0d want good=%b/%b len=%0d",
                             i, obs_q[i].good, j_obs_q[i].good, obs_q[i].len,
                             exp_q[i].good, j_exp_q[i].good, exp_q[i].len);
                end
            end
        end
        checks++;
        if ({good_frames, bad_frames, good_bytes, j_good_frames, j_bad_frames, j_good_bytes} !==
            {32'(m_gf[0]), 32'(m_bf[0]), 32'(m_gb[0]), 32'(m_gf[1]), 32'(m_bf[1]), 32'(m_gb[1])}) begin
            errors++;
            $display("FAIL rand_counters: got gf=%0d bf=%0d gb=%0d jgf=%0d jbf=%0d jgb=%0d want %0d %0d %0d %0d %0d %0d",
                     good_frames, bad_frames, good_bytes, j_good_frames, j_bad_frames, j_good_bytes,
                     m_gf[0], m_bf[0], m_gb[0], m_gf[1], m_bf[1], m_gb[1]);
        end
        flush_q();
    endtask

    initial begin
        sys_rst       = 1'b1;
        stats_clear   = 1'b0;
        xif.xgmii_rxd = IDLE_W;
        xif.xgmii_rxc = 8'hFF;
        model_reset();
        test_reset();
        test_standard();
        test_back_to_back();
        test_errors_and_bounds();
        test_oversize();
        test_stats_clear();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
